// File: rtl/vta_pkg.sv
// Shared VTA definitions: opcodes, STORE instruction layout and the store-unit FSM states.
package vta_pkg;

    localparam int unsigned INS_W      = 128;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_GEMM  = 3'd2;

    localparam int unsigned OPCODE_LSB    = 0;
    localparam int unsigned OPCODE_W      = 3;
    localparam int unsigned DEP_LSB       = 3;
    localparam int unsigned DEP_W         = 4;
    localparam int unsigned SRAM_BASE_LSB = 7;
    localparam int unsigned SRAM_BASE_W   = 16;
    localparam int unsigned DRAM_BASE_LSB = 23;
    localparam int unsigned DRAM_BASE_W   = 32;
    localparam int unsigned Y_SIZE_LSB    = 55;
    localparam int unsigned Y_SIZE_W      = 16;
    localparam int unsigned X_SIZE_LSB    = 71;
    localparam int unsigned X_SIZE_W      = 16;
    localparam int unsigned X_STRIDE_LSB  = 87;
    localparam int unsigned X_STRIDE_W    = 16;
    localparam int unsigned RSVD_LSB      = 103;
    localparam int unsigned RSVD_W        = 25;

    // Packed MSB-first, so field order mirrors the bit map above in reverse.
    typedef struct packed {
        logic [RSVD_W-1:0]      rsvd;
        logic [X_STRIDE_W-1:0]  x_stride;
        logic [X_SIZE_W-1:0]    x_size;
        logic [Y_SIZE_W-1:0]    y_size;
        logic [DRAM_BASE_W-1:0] dram_base;
        logic [SRAM_BASE_W-1:0] sram_base;
        logic [DEP_W-1:0]       dep;
        logic [OPCODE_W-1:0]    opcode;
    } store_insn_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } store_state_e;

endpackage

// File: rtl/vta_store_fifo.sv
// Two-entry synchronous skid FIFO holding {last, dram_addr, data} beats for the store unit.
module vta_store_fifo #(
    parameter int unsigned WIDTH = 161,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    // Storage is reset too so the exposed head reads as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/vta_store.sv
// VTA store unit: walks a 2-D tile of the output buffer and streams rows with DRAM addresses.
module vta_store
    import vta_pkg::*;
#(
    parameter int unsigned INS_WIDTH      = 128,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned SRAM_ADR_WIDTH = 16,
    parameter int unsigned DRAM_ADR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INS_WIDTH-1:0]      insn,
    input  logic                      insn_valid,
    output logic                      insn_ready,
    output logic                      out_mem_rd_en,
    output logic [SRAM_ADR_WIDTH-1:0] out_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     out_mem_rd_data,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [DATA_WIDTH-1:0]     dout_data,
    output logic [DRAM_ADR_WIDTH-1:0] dout_addr,
    output logic                      dout_last,
    output logic                      done
);

    localparam int unsigned EntryW = 1 + DRAM_ADR_WIDTH + DATA_WIDTH;

    store_state_e r_state, w_state_next;
    store_insn_t  w_insn;

    logic [Y_SIZE_W-1:0]       r_y, r_y_size;
    logic [X_SIZE_W-1:0]       r_x, r_x_size;
    logic [X_STRIDE_W-1:0]     r_x_stride;
    logic [SRAM_ADR_WIDTH-1:0] r_sram_addr;
    logic [DRAM_ADR_WIDTH-1:0] r_dram_addr, r_dram_row, w_dram_next_row;
    logic [DRAM_ADR_WIDTH-1:0] r_pend_addr;
    logic                      r_pend_last;
    logic                      r_inflight;

    logic              w_accept, w_insn_ok, w_issue, w_pop;
    logic              w_x_end, w_y_end, w_last;
    logic [1:0]        w_fifo_count;
    logic [2:0]        w_occ;
    logic [EntryW-1:0] w_head;
    logic              w_unused_bits;

    assign w_insn        = store_insn_t'(insn);
    assign w_unused_bits = ^{w_insn.dep, w_insn.rsvd};

    assign w_accept  = insn_valid && (r_state == StIdle);
    assign w_insn_ok = (w_insn.opcode == OP_STORE) && (w_insn.y_size != '0)
                       && (w_insn.x_size != '0);

    // Occupancy the FIFO will see once every outstanding read has landed.
    assign w_pop   = dout_valid && dout_ready;
    assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == StRun) && (w_occ < 3'd2);

    assign w_x_end = (r_x == r_x_size - 1'b1);
    assign w_y_end = (r_y == r_y_size - 1'b1);
    assign w_last  = w_x_end && w_y_end;

    assign w_dram_next_row = r_dram_row + DRAM_ADR_WIDTH'(r_x_stride);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = w_insn_ok ? StRun : StDone;
                end
            end
            StRun: begin
                if (w_issue && w_last) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (!r_inflight && (w_occ == 3'd0)) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // SRAM rows of a tile are contiguous, so the read address simply increments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y         <= '0;
            r_x         <= '0;
            r_y_size    <= '0;
            r_x_size    <= '0;
            r_x_stride  <= '0;
            r_sram_addr <= '0;
            r_dram_addr <= '0;
            r_dram_row  <= '0;
            r_pend_addr <= '0;
            r_pend_last <= 1'b0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept && w_insn_ok) begin
                r_y         <= '0;
                r_x         <= '0;
                r_y_size    <= w_insn.y_size;
                r_x_size    <= w_insn.x_size;
                r_x_stride  <= w_insn.x_stride;
                r_sram_addr <= SRAM_ADR_WIDTH'(w_insn.sram_base);
                r_dram_addr <= DRAM_ADR_WIDTH'(w_insn.dram_base);
                r_dram_row  <= DRAM_ADR_WIDTH'(w_insn.dram_base);
            end else if (w_issue) begin
                r_sram_addr <= r_sram_addr + 1'b1;
                r_pend_addr <= r_dram_addr;
                r_pend_last <= w_last;
                if (w_x_end) begin
                    r_x         <= '0;
                    r_y         <= r_y + 1'b1;
                    r_dram_row  <= w_dram_next_row;
                    r_dram_addr <= w_dram_next_row;
                end else begin
                    r_x         <= r_x + 1'b1;
                    r_dram_addr <= r_dram_addr + 1'b1;
                end
            end
        end
    end

    vta_store_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  ({r_pend_last, r_pend_addr, out_mem_rd_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count)
    );

    assign insn_ready      = (r_state == StIdle);
    assign done            = (r_state == StDone);
    assign out_mem_rd_en   = w_issue;
    assign out_mem_rd_addr = r_sram_addr;
    assign dout_valid      = (w_fifo_count != 2'd0);
    assign dout_data       = w_head[DATA_WIDTH-1:0];
    assign dout_addr       = w_head[DATA_WIDTH +: DRAM_ADR_WIDTH];
    assign dout_last       = w_head[EntryW-1];

endmodule

// File: tb/tb_vta_store.sv
// Scoreboard bench for vta_store: directed jobs, backpressure, wrap-around and mid-job reset.
module tb_vta_store;
    import vta_pkg::*;

    typedef struct {
        logic [127:0] data;
        logic [31:0]  addr;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] insn;
    logic         insn_valid;
    logic         insn_ready;
    logic         out_mem_rd_en;
    logic [15:0]  out_mem_rd_addr;
    logic [127:0] out_mem_rd_data;
    logic         dout_valid;
    logic         dout_ready;
    logic [127:0] dout_data;
    logic [31:0]  dout_addr;
    logic         dout_last;
    logic         done;

    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int done_cnt = 0;
    bit toggle_en = 1'b0;

    beat_t       exp_q[$];
    logic [15:0] exp_rd[$];

    bit           stall_prev = 1'b0;
    logic [127:0] prev_data;
    logic [31:0]  prev_addr;
    logic         prev_last;

    vta_store dut (
        .clk             (clk),
        .rst             (rst),
        .insn            (insn),
        .insn_valid      (insn_valid),
        .insn_ready      (insn_ready),
        .out_mem_rd_en   (out_mem_rd_en),
        .out_mem_rd_addr (out_mem_rd_addr),
        .out_mem_rd_data (out_mem_rd_data),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .dout_data       (dout_data),
        .dout_addr       (dout_addr),
        .dout_last       (dout_last),
        .done            (done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [127:0] row_data(input logic [15:0] a);
        return {8{a, a ^ 16'hA5A5}};
    endfunction

    function automatic logic [127:0] mk_insn(input logic [2:0] op, input logic [15:0] sram,
                                             input logic [31:0] dram, input logic [15:0] y,
                                             input logic [15:0] x, input logic [15:0] stride);
        return {25'd0, stride, x, y, dram, sram, 4'hF, op};
    endfunction

    // Output buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (out_mem_rd_en) out_mem_rd_data <= row_data(out_mem_rd_addr);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [15:0] sram, input logic [31:0] dram, input logic last);
        beat_t b;
        b.data = row_data(sram);
        b.addr = dram;
        b.last = last;
        exp_rd.push_back(sram);
        exp_q.push_back(b);
    endtask

    // Monitor: read addresses, delivered beats and stall stability.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (out_mem_rd_en) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got rd_en at addr %0h required none",
                             out_mem_rd_addr);
                end else begin
                    chk("rd_addr", out_mem_rd_addr, exp_rd.pop_front());
                end
            end
            if (stall_prev) begin
                chk("stall_valid", dout_valid, 1'b1);
                chk("stall_data", dout_data, prev_data);
                chk("stall_addr", dout_addr, prev_addr);
                chk("stall_last", dout_last, prev_last);
            end
            stall_prev = dout_valid && !dout_ready;
            prev_data  = dout_data;
            prev_addr  = dout_addr;
            prev_last  = dout_last;
            if (dout_valid && dout_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: got addr %0h required no beat", dout_addr);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_data", dout_data, b.data);
                    chk("beat_addr", dout_addr, b.addr);
                    chk("beat_last", dout_last, b.last);
                end
            end
            if (done) done_cnt++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (toggle_en) dout_ready = ~dout_ready;
    end

    // exp_first_*: -1 skip, 0 expect none at all, >0 required cycle of first occurrence.
    task automatic run_job(input string tag, input logic [127:0] ins, input int exp_done,
                           input int exp_rd1, input int exp_vld1);
        int  k = 0;
        int  first_rd = -1;
        int  first_vld = -1;
        int  rd_cnt = 0;
        int  vld_cnt = 0;
        bit  seen = 1'b0;
        @(posedge clk);
        #1;
        insn       = ins;
        insn_valid = 1'b1;
        @(posedge clk);
        #1;
        insn_valid = 1'b0;
        while (!seen && k < 2000) begin
            k++;
            @(negedge clk);
            if (k == 1) chk({tag, "_busy_ready"}, insn_ready, 1'b0);
            if (out_mem_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = k;
            end
            if (dout_valid) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = k;
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles required done", tag, k);
        end else begin
            if (exp_done >= 0) chk({tag, "_done_cycle"}, k, exp_done);
            if (exp_rd1 == 0) chk({tag, "_rd_count"}, rd_cnt, 0);
            else if (exp_rd1 > 0) chk({tag, "_first_rd"}, first_rd, exp_rd1);
            if (exp_vld1 == 0) chk({tag, "_vld_count"}, vld_cnt, 0);
            else if (exp_vld1 > 0) chk({tag, "_first_vld"}, first_vld, exp_vld1);
        end
        chk({tag, "_beats_left"}, exp_q.size(), 0);
        chk({tag, "_reads_left"}, exp_rd.size(), 0);
    endtask

    task automatic exp_job1();
        for (int i = 0; i < 8; i++) begin
            push_beat(16'd16 + 16'(i), (i < 4) ? 32'h1000 + i : 32'h1008 + (i - 4), i == 7);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int d0;
        int k;
        rst        = 1'b1;
        insn       = '0;
        insn_valid = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_insn_ready", insn_ready, 1'b1);
        chk("rst_rd_en", out_mem_rd_en, 1'b0);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_dout_data", dout_data, 128'd0);
        chk("rst_done", done, 1'b0);

        // Basic 2x4 tile, no backpressure.
        exp_job1();
        run_job("job1", mk_insn(OP_STORE, 16'd16, 32'h1000, 16'd2, 16'd4, 16'd8), 11, 1, 3);

        // Same tile with dout_ready toggling every cycle.
        exp_job1();
        toggle_en = 1'b1;
        run_job("job2", mk_insn(OP_STORE, 16'd16, 32'h1000, 16'd2, 16'd4, 16'd8), -1, 1, -1);
        toggle_en = 1'b0;
        @(posedge clk);
        #2 dout_ready = 1'b1;

        // Non-STORE opcode and zero-width tile complete immediately.
        run_job("gemm", mk_insn(OP_GEMM, 16'd16, 32'h1000, 16'd2, 16'd4, 16'd8), 1, 0, 0);
        run_job("xzero", mk_insn(OP_STORE, 16'd16, 32'h1000, 16'd2, 16'd0, 16'd8), 1, 0, 0);

        // SRAM row index wraps at 16 bits.
        push_beat(16'hFFFE, 32'h200, 1'b0);
        push_beat(16'hFFFF, 32'h201, 1'b0);
        push_beat(16'h0000, 32'h202, 1'b0);
        push_beat(16'h0001, 32'h203, 1'b1);
        run_job("sram_wrap", mk_insn(OP_STORE, 16'hFFFE, 32'h200, 16'd1, 16'd4, 16'd4), 7, 1, 3);

        // DRAM row address wraps at 32 bits.
        push_beat(16'd5, 32'hFFFF_FFFF, 1'b0);
        push_beat(16'd6, 32'h0000_0000, 1'b1);
        run_job("dram_wrap", mk_insn(OP_STORE, 16'd5, 32'hFFFF_FFFF, 16'd2, 16'd1, 16'd1), 5,
                1, 3);

        // Reset in the middle of a 4x4 job.
        for (int i = 0; i < 16; i++) begin
            push_beat(16'h40 + 16'(i), 32'h2000 + 32'((i / 4) * 16 + (i % 4)), i == 15);
        end
        b0 = beats_seen;
        @(posedge clk);
        #1;
        insn       = mk_insn(OP_STORE, 16'h40, 32'h2000, 16'd4, 16'd4, 16'd16);
        insn_valid = 1'b1;
        @(posedge clk);
        #1 insn_valid = 1'b0;
        k = 0;
        while (beats_seen < b0 + 3 && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (beats_seen < b0 + 3) begin
            checks++; errors++;
            $display("FAIL rst_job_timeout: got %0d beats required 3", beats_seen - b0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_rd_en", out_mem_rd_en, 1'b0);
        chk("midrst_rd_addr", out_mem_rd_addr, 16'd0);
        chk("midrst_valid", dout_valid, 1'b0);
        chk("midrst_data", dout_data, 128'd0);
        chk("midrst_addr", dout_addr, 32'd0);
        chk("midrst_last", dout_last, 1'b0);
        chk("midrst_done", done, 1'b0);
        exp_q.delete();
        exp_rd.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        chk("postrst_ready", insn_ready, 1'b1);
        repeat (20) @(negedge clk);
        chk("postrst_no_done", done_cnt, d0);

        // Fresh job after reset starts from beat 0.
        exp_job1();
        run_job("job_after_rst", mk_insn(OP_STORE, 16'd16, 32'h1000, 16'd2, 16'd4, 16'd8), 11,
                1, 3);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vta_store.md
# vta_store

Store unit: the reader side of the GEMM core's output buffer. It accepts one 128-bit STORE instruction, reads a 2-D tile of rows from the output buffer and streams each row with its DRAM row address over a valid/ready interface to the DRAM writer. It sits between the GEMM core's output buffer and the memory/DMA port, and signals completion to the instruction fetch.

## Interface
- INS_WIDTH, 128, instruction width
- DATA_WIDTH, 128, output-buffer row width (16 x 8-bit)
- SRAM_ADR_WIDTH, 16, output-buffer row index width
- DRAM_ADR_WIDTH, 32, DRAM row address width
- FIFO_DEPTH, 2, output skid FIFO depth; fixed at 2
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- insn  in  INS_WIDTH  instruction
- insn_valid  in  1  instruction offered
- insn_ready  out  1  high only in IDLE; reset value 1 after release
- out_mem_rd_en  out  1  buffer read strobe; reset 0
- out_mem_rd_addr  out  SRAM_ADR_WIDTH  buffer row index; reset 0
- out_mem_rd_data  in  DATA_WIDTH  row data, valid 1 cycle after rd_en
- dout_valid  out  1  beat available; reset 0
- dout_ready  in  1  sink accepts beat
- dout_data  out  DATA_WIDTH  row data; reset 0
- dout_addr  out  DRAM_ADR_WIDTH  DRAM row address; reset 0
- dout_last  out  1  final beat of instruction; reset 0
- done  out  1  one-cycle pulse at completion; reset 0

## Operation
- Instruction fields: [2:0] opcode (STORE = 3'd1), [6:3] dependency flags (ignored), [22:7] sram_base, [54:23] dram_base, [70:55] y_size, [86:71] x_size, [102:87] x_stride, [127:103] unused.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: insn_valid & insn_ready latches fields. If opcode != STORE, y_size == 0 or x_size == 0 -> DONE with no reads or beats; else -> RUN.
- RUN: beat n = (y, x), y in 0..y_size-1 outer, x in 0..x_size-1 inner. SRAM row = sram_base + y*x_size + x; DRAM row = dram_base + y*x_stride + x. Computed with running counters/adders, no multipliers. SRAM sum wraps mod 2^16, DRAM mod 2^32.
- Read issued when fifo_count + inflight - pop < 2 (pop = dout_valid & dout_ready that cycle); data and its DRAM address enter the FIFO the following cycle. After the last read is issued -> DRAIN.
- DRAIN: FIFO empty and nothing in flight -> DONE.
- DONE: done = 1 for one cycle -> IDLE.
- dout_last set on the beat with y = y_size-1, x = x_size-1.
- x_stride < x_size is legal (rows overlap in DRAM); no check.

## Timing
- Accept at edge T: first out_mem_rd_en at T+1, first dout_valid at T+3.
- Sustained throughput 1 beat/cycle with dout_ready held high.
- Total cycles accept->done = y_size*x_size + 3 with no backpressure. Invalid or zero-size instruction: done at T+1.
- dout_valid, once high, holds with data/addr/last stable until dout_ready.
- No combinational path from dout_ready to dout_valid or dout_data. Combinational dout_ready -> out_mem_rd_en via the credit rule is permitted.
- insn_valid outside IDLE is ignored (insn_ready = 0).
- Reset asserted mid-operation: state -> IDLE, FIFO and counters cleared, in-flight read data discarded, all outputs return to reset values asynchronously. No done pulse is produced.

## Structure
- Shared package vta_pkg: opcode constants (OP_STORE = 3'd1), instruction field LSB/width constants, and the store-instruction struct/typedef.
- One sub-module, vta_store_fifo: a 2-entry synchronous FIFO of {last, dram_addr, data} with count, push, and pop.
- Top level holds the FSM, the y/x counters, the address accumulators, and inflight/credit logic.

## Test plan
- sram_base=16, dram_base=0x1000, y=2, x=4, stride=8, dout_ready=1 -> 8 beats, SRAM rows 16..23, DRAM 0x1000..0x1003 then 0x1008..0x100B, last on beat 8, done 11 cycles after accept.
- Same instruction, dout_ready toggled 1/0 each cycle -> same 8 beats in order, no drop or duplicate, outputs stable while stalled.
- opcode=3'd2 (GEMM), then x_size=0 -> no rd_en, no dout_valid, done exactly 1 cycle after accept each time.
- sram_base=0xFFFE, y=1, x=4 -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- dram_base=0xFFFFFFFF, y=2, x=1, stride=1 -> DRAM 0xFFFFFFFF then 0x00000000.
- rst pulsed on beat 3 of a y=4, x=4 job -> outputs at reset values immediately, insn_ready=1 after release, no done. A new job then runs cleanly from beat 0.
